mem_port_arbiter: RTL

Shares one single-port instruction/data memory between the fetch stage (read-only requester) and the memory stage (read/write requester) of the 5-stage pipeline.
- Issues one memory transaction at a time and waits for the memory's completion pulse.
- Returns read data and a one-cycle done pulse to the requester.
- Drives per-stage stall lines to the pipeline.
- Data-side priority, with a bounded-starvation rule for fetch and a watchdog timeout.

---
 rtl/mem_port_arbiter_pkg.sv | 29 ++
 rtl/mem_port_arbiter_fair_counter.sv | 38 +++
 rtl/mem_port_arbiter.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_pkg
// Shared definitions for the fetch/data memory port arbiter: FSM state
// encodings, default parameter values and internal counter widths.
// No ports (package).
// -----------------------------------------------------------------------------
package mem_port_arbiter_pkg;

    localparam int DEF_AW         = 32;
    localparam int DEF_DW         = 32;
    localparam int DEF_FAIR_LIMIT = 4;
    localparam int DEF_TIMEOUT    = 255;

    // FAIR_LIMIT tops out at 15 and TIMEOUT at 255.
    localparam int STREAK_W = 4;
    localparam int WDOG_W   = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY_IF = 2'd1,
        ST_BUSY_D  = 2'd2
    } arb_state_e;

    // The watchdog counts from 0, so the last busy cycle is TIMEOUT-1.
    function automatic logic [WDOG_W-1:0] wdog_last(input int timeout);
        return WDOG_W'(timeout - 1);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_fair_counter.sv
// -----------------------------------------------------------------------------
// arb_fair_counter
// Saturating count of consecutive data grants made while fetch was waiting.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_clr          : clear the streak (takes priority over i_inc)
//   i_inc          : one more data grant while fetch waits
//   o_at_limit     : streak has reached LIMIT; fetch gets the next tie
// -----------------------------------------------------------------------------
module arb_fair_counter
    import mem_port_arbiter_pkg::*;
#(
    parameter int LIMIT = DEF_FAIR_LIMIT
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_at_limit
);

    localparam logic [STREAK_W-1:0] LIMIT_VAL = STREAK_W'(LIMIT);

    logic [STREAK_W-1:0] r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && (r_count != LIMIT_VAL)) begin
            r_count <= r_count + STREAK_W'(1);
        end
    end

    assign o_at_limit = (r_count == LIMIT_VAL);

endmodule

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-port memory between the fetch stage (read-only) and the
// memory stage (read/write). One transaction in flight at a time; data side
// has priority, bounded by a fairness streak, and a watchdog aborts a
// transaction whose completion never arrives.
// Ports:
//   CLK, RST                       : clock, asynchronous active-low reset
//   if_req/if_addr                 : fetch request (level) and address
//   if_done/if_rdata/if_stall      : fetch completion pulse, data, stall
//   d_req/d_we/d_addr/d_wdata      : data request (level) and payload
//   d_done/d_rdata/d_stall         : data completion pulse, data, stall
//   mem_req/mem_we/mem_addr/mem_wdata : issue strobe and latched command
//   mem_rdata/mem_done             : memory read data and completion pulse
//   err                            : sticky, a transaction timed out
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_IDLE    | no transaction in flight; choose a grant this cycle
// ST_BUSY_IF | fetch read issued, waiting for mem_done or watchdog
// ST_BUSY_D  | data read/write issued, waiting for mem_done or watchdog
// -----------------------------------------------------------------------------
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int AW         = DEF_AW,
    parameter int DW         = DEF_DW,
    parameter int FAIR_LIMIT = DEF_FAIR_LIMIT,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_done,
    output logic [DW-1:0] if_rdata,
    output logic          if_stall,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_done,
    output logic [DW-1:0] d_rdata,
    output logic          d_stall,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_done,
    output logic          err
);

    localparam logic [WDOG_W-1:0] WDOG_LAST = wdog_last(TIMEOUT);

    arb_state_e          r_state;
    logic [WDOG_W-1:0]   r_wdog;

    logic w_idle;
    logic w_if_elig;
    logic w_d_elig;
    logic w_at_limit;
    logic w_grant_d;
    logic w_grant_if;
    logic w_wdog_expire;

    // A requester whose done pulse is visible this cycle is still holding
    // req for the transaction just finished, so it must not be re-issued.
    assign w_idle     = (r_state == ST_IDLE);
    assign w_if_elig  = if_req & ~if_done;
    assign w_d_elig   = d_req  & ~d_done;
    assign w_grant_d  = w_idle & w_d_elig & (~w_if_elig | ~w_at_limit);
    assign w_grant_if = w_idle & w_if_elig & ~w_grant_d;

    assign w_wdog_expire = (r_wdog == WDOG_LAST);

    assign if_stall = if_req & ~if_done;
    assign d_stall  = d_req  & ~d_done;

    arb_fair_counter #(
        .LIMIT (FAIR_LIMIT)
    ) u_fair (
        .i_clk      (CLK),
        .i_rst_n    (RST),
        .i_clr      (~if_req | w_grant_if),
        .i_inc      (w_grant_d & if_req),
        .o_at_limit (w_at_limit)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state   <= ST_IDLE;
            r_wdog    <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_done   <= 1'b0;
            if_rdata  <= '0;
            d_done    <= 1'b0;
            d_rdata   <= '0;
            err       <= 1'b0;
        end else begin
            mem_req <= 1'b0;
            if_done <= 1'b0;
            d_done  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_d) begin
                        mem_req   <= 1'b1;
                        mem_we    <= d_we;
                        mem_addr  <= d_addr;
                        mem_wdata <= d_wdata;
                        r_wdog    <= '0;
                        r_state   <= ST_BUSY_D;
                    end else if (w_grant_if) begin
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_addr  <= if_addr;
                        mem_wdata <= '0;
                        r_wdog    <= '0;
                        r_state   <= ST_BUSY_IF;
                    end
                end
                ST_BUSY_IF: begin
                    if (mem_done) begin
                        if_done  <= 1'b1;
                        if_rdata <= mem_rdata;
                        r_state  <= ST_IDLE;
                    end else if (w_wdog_expire) begin
                        err      <= 1'b1;
                        if_done  <= 1'b1;
                        if_rdata <= '0;
                        r_state  <= ST_IDLE;
                    end else begin
                        r_wdog <= r_wdog + WDOG_W'(1);
                    end
                end
                ST_BUSY_D: begin
                    if (mem_done) begin
                        d_done  <= 1'b1;
                        // writes return zero rather than whatever the bus carried
                        d_rdata <= mem_we ? '0 : mem_rdata;
                        r_state <= ST_IDLE;
                    end else if (w_wdog_expire) begin
                        err     <= 1'b1;
                        d_done  <= 1'b1;
                        d_rdata <= '0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_wdog <= r_wdog + WDOG_W'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
